// File: rtl/fft_sample_feeder_if.sv
// fft_sample_feeder_if: bundles the core-side sample write port and start
// control with the FFT-side streaming outputs of fft_sample_feeder.
//   master : core bus decoder side (drives writes/start, observes status/stream)
//   slave  : fft_sample_feeder side
//   wr_en/wr_addr/wr_data : one sample write per cycle; real in [11:0], imag in [27:16]
//   start                 : single-cycle pulse requesting a 32-sample burst
//   busy/done/wr_err      : burst status, end-of-burst pulse, sticky dropped-write flag
//   in_valid/din_r/din_i  : streaming sample interface toward the FFT input
interface fft_sample_feeder_if #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned SAMPLE_W = 12,
   parameter int unsigned DATA_W   = 32
);
   logic                       wr_en;
   logic [ADDR_W-1:0]          wr_addr;
   logic [DATA_W-1:0]          wr_data;
   logic                       start;
   logic                       busy;
   logic                       done;
   logic                       wr_err;
   logic                       in_valid;
   logic signed [SAMPLE_W-1:0] din_r;
   logic signed [SAMPLE_W-1:0] din_i;

   modport master (
      output wr_en, wr_addr, wr_data, start,
      input  busy, done, wr_err, in_valid, din_r, din_i
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start,
      output busy, done, wr_err, in_valid, din_r, din_i
   );
endinterface

// File: rtl/fft_sample_feeder.sv
// fft_sample_feeder: buffers 32 complex samples written by the core and, on
// start, replays them to the FFT as one gap-free 32-cycle burst.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (sample buffer is not reset)
//   bus     : fft_sample_feeder_if.slave (write port, start, status, FFT stream)
// Build option:
//   FFT_FEEDER_PINGPONG_EN : two buffer banks; writes fill one bank while the
//                            other is streamed, and each accepted start swaps them.
//                            Undefined: single bank, writes during a burst are
//                            dropped and flagged on wr_err.
module fft_sample_feeder (
   input  logic              clk,
   input  logic              reset_n,
   fft_sample_feeder_if.slave bus
);
   localparam int unsigned N_POINTS = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned SAMPLE_W = 12;
`ifdef FFT_FEEDER_PINGPONG_EN
   localparam int unsigned PTR_W    = ADDR_W + 1;
`else
   localparam int unsigned PTR_W    = ADDR_W;
`endif
   localparam int unsigned MEM_DEPTH = 2 ** PTR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] im;
      logic signed [SAMPLE_W-1:0] re;
   } sample_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [ADDR_W-1:0]          idx_q, idx_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       wr_err_q, wr_err_d;
   logic                       in_valid_q, in_valid_d;
   logic signed [SAMPLE_W-1:0] din_r_q, din_r_d;
   logic signed [SAMPLE_W-1:0] din_i_q, din_i_d;

   sample_t                    mem [MEM_DEPTH];
   sample_t                    wr_sample_c;
   sample_t                    rd_sample_c;
   sample_t                    tx_sample_c;
   logic [PTR_W-1:0]           wr_ptr_c;
   logic [PTR_W-1:0]           rd_ptr_c;
   logic [ADDR_W-1:0]          rd_idx_c;
   logic                       start_acc_c;
   logic                       wr_acc_c;
   logic                       unused_wr_bits_c;

   // Only the two 12-bit fields of the write word carry sample data.
   assign wr_sample_c      = '{im: bus.wr_data[27:16], re: bus.wr_data[11:0]};
   assign unused_wr_bits_c = ^{bus.wr_data[31:28], bus.wr_data[15:12]};

   assign start_acc_c = bus.start && (state_q == S_IDLE);

   // Index of the sample loaded into the output register at the coming edge.
   assign rd_idx_c = (state_q == S_STREAM) ? idx_q + ADDR_W'(1) : '0;

`ifdef FFT_FEEDER_PINGPONG_EN
   logic fill_q, fill_d;
   logic rd_bank_c;

   // While streaming the send bank is the one not being filled; in IDLE the
   // fill bank is about to become the send bank on an accepted start.
   assign rd_bank_c = (state_q == S_STREAM) ? ~fill_q : fill_q;
   assign wr_acc_c  = bus.wr_en;
   assign wr_ptr_c  = {fill_q, bus.wr_addr};
   assign rd_ptr_c  = {rd_bank_c, rd_idx_c};
   assign fill_d    = start_acc_c ? ~fill_q : fill_q;

   // Bank select register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_q <= 1'b0;
      end else begin
         fill_q <= fill_d;
      end
   end
`else
   assign wr_acc_c = bus.wr_en && (state_q != S_STREAM);
   assign wr_ptr_c = bus.wr_addr;
   assign rd_ptr_c = rd_idx_c;
`endif

   // A write landing at the same edge as the read wins, so start+write sends the new value.
   assign rd_sample_c = mem[rd_ptr_c];
   assign tx_sample_c = (wr_acc_c && (wr_ptr_c == rd_ptr_c)) ? wr_sample_c : rd_sample_c;

   // Sample buffer, intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_acc_c) begin
         mem[wr_ptr_c] <= wr_sample_c;
      end
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      wr_err_d   = wr_err_q;
      in_valid_d = 1'b0;
      din_r_d    = '0;
      din_i_d    = '0;

      case (state_q)
         S_IDLE: begin
            if (start_acc_c) begin
               state_d    = S_STREAM;
               idx_d      = '0;
               busy_d     = 1'b1;
               wr_err_d   = 1'b0;
               in_valid_d = 1'b1;
               din_r_d    = tx_sample_c.re;
               din_i_d    = tx_sample_c.im;
            end
         end
         S_STREAM: begin
`ifndef FFT_FEEDER_PINGPONG_EN
            if (bus.wr_en) begin
               wr_err_d = 1'b1;
            end
`endif
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
               idx_d   = '0;
               done_d  = 1'b1;
            end else begin
               idx_d      = idx_q + ADDR_W'(1);
               busy_d     = 1'b1;
               in_valid_d = 1'b1;
               din_r_d    = tx_sample_c.re;
               din_i_d    = tx_sample_c.im;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_err_q   <= 1'b0;
         in_valid_q <= 1'b0;
         din_r_q    <= '0;
         din_i_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_err_q   <= wr_err_d;
         in_valid_q <= in_valid_d;
         din_r_q    <= din_r_d;
         din_i_q    <= din_i_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.wr_err   = wr_err_q;
   assign bus.in_valid = in_valid_q;
   assign bus.din_r    = din_r_q;
   assign bus.din_i    = din_i_q;
endmodule

// File: tb/tb_fft_sample_feeder.sv
// tb_fft_sample_feeder: directed, self-checking bench for fft_sample_feeder.
module tb_fft_sample_feeder;
`ifdef FFT_FEEDER_PINGPONG_EN
   localparam bit PINGPONG = 1'b1;
`else
   localparam bit PINGPONG = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   fft_sample_feeder_if bus_if ();

   fft_sample_feeder dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   typedef struct {
      string       name;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [11:0] exp_r;
      logic [11:0] exp_i;
   } vec_t;

   vec_t        vecs [4];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [11:0] exp_r [2][32];
   logic [11:0] exp_i [2][32];
   int          fill_bank = 0;
   int          send_bank = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus_if.wr_en   = 1'b1;
      bus_if.wr_addr = a;
      bus_if.wr_data = d;
      tick();
      bus_if.wr_en   = 1'b0;
   endtask

   task automatic model_start();
      if (PINGPONG) begin
         send_bank = fill_bank;
         fill_bank = fill_bank ^ 1;
      end else begin
         send_bank = 0;
      end
   endtask

   task automatic do_start();
      bus_if.start = 1'b1;
      model_start();
      tick();
      bus_if.start = 1'b0;
   endtask

   task automatic write_ramp();
      for (int k = 0; k < 32; k++) begin
         wr(5'(k), {4'h0, 12'(-k), 4'h0, 12'(k)});
         exp_r[fill_bank][k] = 12'(k);
         exp_i[fill_bank][k] = 12'(-k);
      end
   endtask

   // Entered in the first burst cycle; leaves in the done cycle.
   task automatic stream_check(input string tag, input int restart_at, input int wr_at,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic [11:0] wr_r, input logic [11:0] wr_i,
                               input logic exp_err);
      for (int c = 0; c < 32; c++) begin
         chk($sformatf("%s in_valid[%0d]", tag, c), {31'h0, bus_if.in_valid}, 32'd1);
         chk($sformatf("%s busy[%0d]", tag, c), {31'h0, bus_if.busy}, 32'd1);
         chk($sformatf("%s din_r[%0d]", tag, c), {20'h0, bus_if.din_r}, {20'h0, exp_r[send_bank][c]});
         chk($sformatf("%s din_i[%0d]", tag, c), {20'h0, bus_if.din_i}, {20'h0, exp_i[send_bank][c]});
         if (c == restart_at) bus_if.start = 1'b1;
         if (c == wr_at) begin
            bus_if.wr_en   = 1'b1;
            bus_if.wr_addr = wa;
            bus_if.wr_data = wd;
         end
         tick();
         bus_if.start = 1'b0;
         bus_if.wr_en = 1'b0;
         if (c == wr_at && PINGPONG) begin
            exp_r[fill_bank][wa] = wr_r;
            exp_i[fill_bank][wa] = wr_i;
         end
      end
      chk({tag, " done"}, {31'h0, bus_if.done}, 32'd1);
      chk({tag, " in_valid_after"}, {31'h0, bus_if.in_valid}, 32'd0);
      chk({tag, " busy_after"}, {31'h0, bus_if.busy}, 32'd0);
      chk({tag, " din_r_after"}, {20'h0, bus_if.din_r}, 32'd0);
      chk({tag, " wr_err"}, {31'h0, bus_if.wr_err}, {31'h0, exp_err});
   endtask

   initial begin
      vecs[0] = '{"neg_full",  5'd0,  32'hFFFF_F800, 12'h800, 12'hFFF};
      vecs[1] = '{"pos_max",   5'd0,  32'hF7FF_07FF, 12'h7FF, 12'h7FF};
      vecs[2] = '{"last_idx",  5'd31, 32'h5A5A_A5A5, 12'h5A5, 12'hA5A};
      vecs[3] = '{"mid_mixed", 5'd15, 32'h0800_0FFF, 12'hFFF, 12'h800};

      bus_if.wr_en   = 1'b0;
      bus_if.wr_addr = '0;
      bus_if.wr_data = '0;
      bus_if.start   = 1'b0;
      reset_n        = 1'b0;
      tick();
      tick();
      chk("rst busy",     {31'h0, bus_if.busy},     32'd0);
      chk("rst done",     {31'h0, bus_if.done},     32'd0);
      chk("rst wr_err",   {31'h0, bus_if.wr_err},   32'd0);
      chk("rst in_valid", {31'h0, bus_if.in_valid}, 32'd0);
      chk("rst din_r",    {20'h0, bus_if.din_r},    32'd0);
      chk("rst din_i",    {20'h0, bus_if.din_i},    32'd0);
      reset_n = 1'b1;
      tick();

      // Ramp frame
      write_ramp();
      chk("t1 idle in_valid", {31'h0, bus_if.in_valid}, 32'd0);
      do_start();
      chk("t1 last din_i model", {20'h0, exp_i[send_bank][31]}, 32'h0000_0FE1);
      stream_check("t1", -1, -1, 5'd0, 32'h0, 12'h0, 12'h0, 1'b0);
      tick();
      chk("t1 done_once", {31'h0, bus_if.done}, 32'd0);
      if (PINGPONG) write_ramp();

      // Field extraction vectors
      for (int v = 0; v < 4; v++) begin
         wr(vecs[v].addr, vecs[v].data);
         exp_r[fill_bank][vecs[v].addr] = vecs[v].exp_r;
         exp_i[fill_bank][vecs[v].addr] = vecs[v].exp_i;
         do_start();
         if (vecs[v].addr == 5'd0) begin
            chk({vecs[v].name, " first din_r"}, {20'h0, bus_if.din_r}, {20'h0, vecs[v].exp_r});
            chk({vecs[v].name, " first din_i"}, {20'h0, bus_if.din_i}, {20'h0, vecs[v].exp_i});
         end
         stream_check(vecs[v].name, -1, -1, 5'd0, 32'h0, 12'h0, 12'h0, 1'b0);
         tick();
      end

      // Restart during a burst is ignored
      do_start();
      stream_check("t3", 10, -1, 5'd0, 32'h0, 12'h0, 12'h0, 1'b0);
      tick();
      chk("t3 done_once", {31'h0, bus_if.done}, 32'd0);
      chk("t3 idle in_valid", {31'h0, bus_if.in_valid}, 32'd0);

      // Start held through the done cycle: ignored in DONE, accepted one cycle later
      do_start();
      stream_check("t3b", -1, -1, 5'd0, 32'h0, 12'h0, 12'h0, 1'b0);
      bus_if.start = 1'b1;
      tick();
      chk("t3b start_in_done in_valid", {31'h0, bus_if.in_valid}, 32'd0);
      chk("t3b start_in_done busy",     {31'h0, bus_if.busy},     32'd0);
      model_start();
      tick();
      bus_if.start = 1'b0;
      stream_check("t3c", -1, -1, 5'd0, 32'h0, 12'h0, 12'h0, 1'b0);
      tick();

      // Write during busy
      do_start();
      stream_check("t4", -1, 12, 5'd5, 32'h0123_0456, 12'h456, 12'h123, !PINGPONG);
      tick();
      chk("t4 wr_err sticky", {31'h0, bus_if.wr_err}, {31'h0, !PINGPONG});
      do_start();
      chk("t4 wr_err cleared", {31'h0, bus_if.wr_err}, 32'd0);
      stream_check("t4b", -1, -1, 5'd0, 32'h0, 12'h0, 12'h0, 1'b0);
      tick();

      // Reset mid-burst
      do_start();
      for (int c = 0; c < 12; c++) tick();
      chk("t5 pre_rst in_valid", {31'h0, bus_if.in_valid}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5 rst in_valid", {31'h0, bus_if.in_valid}, 32'd0);
      chk("t5 rst busy",     {31'h0, bus_if.busy},     32'd0);
      chk("t5 rst din_r",    {20'h0, bus_if.din_r},    32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("t5 no_done[%0d]", c), {31'h0, bus_if.done}, 32'd0);
      end
      reset_n   = 1'b1;
      fill_bank = 0;
      tick();
      chk("t5 post_rst done", {31'h0, bus_if.done}, 32'd0);
      do_start();
      stream_check("t5", -1, -1, 5'd0, 32'h0, 12'h0, 12'h0, 1'b0);
      tick();

      // Start and write in the same IDLE cycle
      bus_if.start   = 1'b1;
      bus_if.wr_en   = 1'b1;
      bus_if.wr_addr = 5'd0;
      bus_if.wr_data = 32'h0000_0007;
      exp_r[fill_bank][0] = 12'h007;
      exp_i[fill_bank][0] = 12'h000;
      model_start();
      tick();
      bus_if.start = 1'b0;
      bus_if.wr_en = 1'b0;
      chk("t6 first din_r", {20'h0, bus_if.din_r}, 32'd7);
      stream_check("t6", -1, -1, 5'd0, 32'h0, 12'h0, 12'h0, 1'b0);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
